// File: rtl/gps_wb_regbank_mc_if.sv
// Wishbone classic slave bundle for the GPS register bank.
//   master: drives wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_stb_i/wb_cyc_i,
//           samples wb_dat_o/wb_ack_o.
//   slave : the reverse.
// Signal names keep the bank's own _i/_o view of the bus.
interface gps_wb_regbank_mc_if;
  logic [9:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
                  input  wb_dat_o, wb_ack_o);
  modport slave  (input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
                  output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/gps_wb_regbank_mc.sv
// Multi-channel Wishbone register bank for the GPS baseband tracking channels.
// Ports:
//   wb_clk_i, wb_rst_i      clock, async active-low reset
//   wb (slave)              Wishbone bus, registered single-cycle ack
//   irq_o                   registered |(READY & IRQ_EN)
//   code/carr_freq_o, code/carr_off_o, ch_enable_o, sat_id_o
//                           per-channel NCO and control words (ch n at slice n)
//   pi/pq/li/lq/ei/eq_i     per-channel correlator dumps
//   intg_ready_i            per-channel dump-ready level (asynchronous)
//   acq_complete_i          acquisition done levels, readable at global 0x0C
//   timestamp_i             shared timestamp, snapshotted with each dump
// Address: [9:6] channel (0xF = global), [5:2] word offset.
module gps_wb_regbank_mc #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 20,
  parameter int FREQ_W = 30
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  gps_wb_regbank_mc_if.slave       wb,
  output logic                     irq_o,
  output logic [NUM_CH*FREQ_W-1:0] code_freq_o,
  output logic [NUM_CH*FREQ_W-1:0] carr_freq_o,
  output logic [NUM_CH*FREQ_W-1:0] code_off_o,
  output logic [NUM_CH*FREQ_W-1:0] carr_off_o,
  output logic [NUM_CH-1:0]        ch_enable_o,
  output logic [NUM_CH*5-1:0]      sat_id_o,
  input  logic [NUM_CH*ACC_W-1:0]  pi_i,
  input  logic [NUM_CH*ACC_W-1:0]  pq_i,
  input  logic [NUM_CH*ACC_W-1:0]  li_i,
  input  logic [NUM_CH*ACC_W-1:0]  lq_i,
  input  logic [NUM_CH*ACC_W-1:0]  ei_i,
  input  logic [NUM_CH*ACC_W-1:0]  eq_i,
  input  logic [NUM_CH-1:0]        intg_ready_i,
  input  logic [NUM_CH-1:0]        acq_complete_i,
  input  logic [31:0]              timestamp_i
);
  localparam logic [3:0] GLB = 4'hF;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] m,
                                        input logic [31:0] d);
    return (old & ~m) | (d & m);
  endfunction

  logic        req, wr, wr_glb;
  logic [3:0]  sel_ch, off;
  logic [31:0] bm, wdat_m, rdata;
  logic [NUM_CH-1:0] ready, ovr, irq_en, ev, clr, oclr;
  logic [NUM_CH-1:0][31:0] rd_ch;

  // ~ack turns a held strobe into one transfer every second cycle
  assign req    = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
  assign wr     = req & wb.wb_we_i;
  assign sel_ch = wb.wb_adr_i[9:6];
  assign off    = wb.wb_adr_i[5:2];
  assign wr_glb = wr & (sel_ch == GLB);
  assign bm     = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                   {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
  assign wdat_m = wb.wb_dat_i & bm;
  assign clr    = (wr_glb && off == 4'h0) ? wdat_m[NUM_CH-1:0] : '0;
  assign oclr   = (wr_glb && off == 4'h1) ? wdat_m[NUM_CH-1:0] : '0;

  logic unused_adr;
  assign unused_adr = ^wb.wb_adr_i[1:0];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic              wr_ch, s1, s2, s3, en;
    logic [4:0]        sat;
    logic [FREQ_W-1:0] cf, caf, co, cao;
    logic [5:0][ACC_W-1:0] sh, corr;
    logic [31:0]       ts, ctrl_rd, ctrl_nx, rd;
    logic              unused_ctrl;

    assign wr_ch   = wr & (sel_ch == 4'(n));
    assign corr    = {eq_i[n*ACC_W +: ACC_W], ei_i[n*ACC_W +: ACC_W],
                      lq_i[n*ACC_W +: ACC_W], li_i[n*ACC_W +: ACC_W],
                      pq_i[n*ACC_W +: ACC_W], pi_i[n*ACC_W +: ACC_W]};
    assign ctrl_rd = {23'b0, sat, 3'b0, en};
    assign ctrl_nx = merge(ctrl_rd, bm, wb.wb_dat_i);
    assign unused_ctrl = ^{ctrl_nx[31:9], ctrl_nx[3:1]};
    // s1/s2 synchronise; s3 keeps the previous s2 for rising-edge detect
    assign ev[n]   = s2 & ~s3;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
        {s1, s2, s3} <= '0;
        cf <= '0; caf <= '0; co <= '0; cao <= '0;
        en <= 1'b0; sat <= '0; sh <= '0; ts <= '0;
      end else begin
        s1 <= intg_ready_i[n];
        s2 <= s1;
        s3 <= s2;
        if (s2 & ~s3) begin
          sh <= corr;
          ts <= timestamp_i;
        end
        if (wr_ch) begin
          case (off)
            4'h0: cf  <= FREQ_W'(merge(32'(cf),  bm, wb.wb_dat_i));
            4'h1: caf <= FREQ_W'(merge(32'(caf), bm, wb.wb_dat_i));
            4'h2: co  <= FREQ_W'(merge(32'(co),  bm, wb.wb_dat_i));
            4'h3: cao <= FREQ_W'(merge(32'(cao), bm, wb.wb_dat_i));
            4'h4: begin
              en  <= ctrl_nx[0];
              sat <= ctrl_nx[8:4];
            end
            default: ;
          endcase
        end
      end
    end

    always_comb begin
      rd = '0;
      case (off)
        4'h0: rd = 32'(cf);
        4'h1: rd = 32'(caf);
        4'h2: rd = 32'(co);
        4'h3: rd = 32'(cao);
        4'h4: rd = ctrl_rd;
        4'h5: rd = 32'(sh[0]);
        4'h6: rd = 32'(sh[1]);
        4'h7: rd = 32'(sh[2]);
        4'h8: rd = 32'(sh[3]);
        4'h9: rd = 32'(sh[4]);
        4'hA: rd = 32'(sh[5]);
        4'hB: rd = ts;
        default: rd = '0;
      endcase
    end

    assign rd_ch[n] = rd;
    assign code_freq_o[n*FREQ_W +: FREQ_W] = cf;
    assign carr_freq_o[n*FREQ_W +: FREQ_W] = caf;
    assign code_off_o[n*FREQ_W +: FREQ_W]  = co;
    assign carr_off_o[n*FREQ_W +: FREQ_W]  = cao;
    assign ch_enable_o[n]                  = en;
    assign sat_id_o[n*5 +: 5]              = sat;
  end

  always_comb begin
    rdata = '0;
    if (sel_ch == GLB) begin
      case (off)
        4'h0: rdata = 32'(ready);
        4'h1: rdata = 32'(ovr);
        4'h2: rdata = 32'(irq_en);
        4'h3: rdata = 32'(acq_complete_i);
        default: rdata = '0;
      endcase
    end else begin
      for (int n = 0; n < NUM_CH; n++)
        if (sel_ch == 4'(n)) rdata = rd_ch[n];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      ready       <= '0;
      ovr         <= '0;
      irq_en      <= '0;
      irq_o       <= 1'b0;
    end else begin
      wb.wb_ack_o <= req;
      if (req) wb.wb_dat_o <= rdata;
      // a capture beats a same-cycle clear; overrun only if the old flag survives
      ready <= (ready & ~clr) | ev;
      ovr   <= (ovr & ~oclr) | (ev & ready & ~clr);
      if (wr_glb && off == 4'h2)
        irq_en <= NUM_CH'(merge(32'(irq_en), bm, wb.wb_dat_i));
      irq_o <= |(ready & irq_en);
    end
  end
endmodule

// File: tb/tb_gps_wb_regbank_mc.sv
module tb_gps_wb_regbank_mc;
  localparam int NUM_CH = 4, ACC_W = 20, FREQ_W = 30;
  localparam logic [63:0] FM64 = (64'd1 << FREQ_W) - 64'd1;
  localparam logic [63:0] AM64 = (64'd1 << ACC_W) - 64'd1;
  localparam logic [31:0] FMASK = FM64[31:0];
  localparam logic [31:0] AMASK = AM64[31:0];

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  gps_wb_regbank_mc_if bus();
  logic irq;
  logic [NUM_CH*FREQ_W-1:0] code_freq, carr_freq, code_off, carr_off;
  logic [NUM_CH-1:0] ch_en, intg, acq;
  logic [NUM_CH*5-1:0] sat_id;
  logic [NUM_CH*ACC_W-1:0] pi, pq, li, lq, ei, eq;
  logic [31:0] ts;

  gps_wb_regbank_mc #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .FREQ_W(FREQ_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb(bus.slave), .irq_o(irq),
    .code_freq_o(code_freq), .carr_freq_o(carr_freq), .code_off_o(code_off),
    .carr_off_o(carr_off), .ch_enable_o(ch_en), .sat_id_o(sat_id),
    .pi_i(pi), .pq_i(pq), .li_i(li), .lq_i(lq), .ei_i(ei), .eq_i(eq),
    .intg_ready_i(intg), .acq_complete_i(acq), .timestamp_i(ts));

  int n_cmp = 0, n_err = 0;

  // reference model: plain register contents
  logic [31:0] m_cf[NUM_CH], m_caf[NUM_CH], m_co[NUM_CH], m_cao[NUM_CH], m_ctrl[NUM_CH];
  logic [31:0] m_sh[NUM_CH][6], m_ts[NUM_CH];
  logic [NUM_CH-1:0] m_rdy, m_ovr, m_ien;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [9:0] a);
    int c = int'(a[9:6]);
    int o = int'(a[5:0]);
    if (c == 15) begin
      case (o)
        0: return 32'(m_rdy);
        4: return 32'(m_ovr);
        8: return 32'(m_ien);
        12: return 32'(acq);
        default: return 32'h0;
      endcase
    end
    if (c >= NUM_CH) return 32'h0;
    case (o)
      0: return m_cf[c];
      4: return m_caf[c];
      8: return m_co[c];
      12: return m_cao[c];
      16: return m_ctrl[c];
      20, 24, 28, 32, 36, 40: return m_sh[c][(o - 20) / 4];
      44: return m_ts[c];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    int c = int'(a[9:6]);
    int o = int'(a[5:0]);
    logic [31:0] wm = bmerge(32'h0, d, s);
    logic [31:0] t;
    if (c == 15) begin
      case (o)
        0: m_rdy &= ~wm[NUM_CH-1:0];
        4: m_ovr &= ~wm[NUM_CH-1:0];
        8: begin t = bmerge(32'(m_ien), d, s); m_ien = t[NUM_CH-1:0]; end
        default: ;
      endcase
    end else if (c < NUM_CH) begin
      case (o)
        0: m_cf[c]   = bmerge(m_cf[c], d, s) & FMASK;
        4: m_caf[c]  = bmerge(m_caf[c], d, s) & FMASK;
        8: m_co[c]   = bmerge(m_co[c], d, s) & FMASK;
        12: m_cao[c] = bmerge(m_cao[c], d, s) & FMASK;
        16: m_ctrl[c] = bmerge(m_ctrl[c], d, s) & 32'h1F1;
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cf[c] = 0; m_caf[c] = 0; m_co[c] = 0; m_cao[c] = 0; m_ctrl[c] = 0; m_ts[c] = 0;
      for (int k = 0; k < 6; k++) m_sh[c][k] = 0;
    end
    m_rdy = 0; m_ovr = 0; m_ien = 0;
  endtask

  // a dump: overrun if the flag is still up, then flag set and newest data kept
  task automatic snap(input int c, input logic [5:0][31:0] v, input logic [31:0] t);
    if (m_rdy[c]) m_ovr[c] = 1'b1;
    m_rdy[c] = 1'b1;
    for (int k = 0; k < 6; k++) m_sh[c][k] = v[k];
    m_ts[c] = t;
  endtask

  task automatic check_outs();
    logic [NUM_CH*FREQ_W-1:0] e_cf, e_caf, e_co, e_cao;
    logic [NUM_CH-1:0] e_en;
    logic [NUM_CH*5-1:0] e_sat;
    for (int c = 0; c < NUM_CH; c++) begin
      e_cf[c*FREQ_W +: FREQ_W]  = m_cf[c][FREQ_W-1:0];
      e_caf[c*FREQ_W +: FREQ_W] = m_caf[c][FREQ_W-1:0];
      e_co[c*FREQ_W +: FREQ_W]  = m_co[c][FREQ_W-1:0];
      e_cao[c*FREQ_W +: FREQ_W] = m_cao[c][FREQ_W-1:0];
      e_en[c] = m_ctrl[c][0];
      e_sat[c*5 +: 5] = m_ctrl[c][8:4];
    end
    chk("code_freq_o", code_freq, e_cf);
    chk("carr_freq_o", carr_freq, e_caf);
    chk("code_off_o", code_off, e_co);
    chk("carr_off_o", carr_off, e_cao);
    chk("ch_enable_o", ch_en, e_en);
    chk("sat_id_o", sat_id, e_sat);
  endtask

  task automatic chk_irq(input string tag);
    chk(tag, irq, |(m_rdy & m_ien));
  endtask

  // called at a negedge; returns at a negedge with the bus idle
  task automatic wb_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    chk("ack_idle", bus.wb_ack_o, 1'b0);
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_sel_i = s;
    bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(negedge clk);
    chk("ack_wr", bus.wb_ack_o, 1'b1);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    @(negedge clk);
    chk("ack_drop", bus.wb_ack_o, 1'b0);
    model_write(a, d, s);
  endtask

  task automatic wb_rd(input string tag, input logic [9:0] a, output logic [31:0] d);
    bus.wb_adr_i = a; bus.wb_sel_i = 4'hF; bus.wb_we_i = 1'b0;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(negedge clk);
    chk("ack_rd", bus.wb_ack_o, 1'b1);
    d = bus.wb_dat_o;
    chk(tag, d, mread(a));
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_corr(input int c, input logic [5:0][31:0] v, input logic [31:0] t);
    pi[c*ACC_W +: ACC_W] = v[0][ACC_W-1:0];
    pq[c*ACC_W +: ACC_W] = v[1][ACC_W-1:0];
    li[c*ACC_W +: ACC_W] = v[2][ACC_W-1:0];
    lq[c*ACC_W +: ACC_W] = v[3][ACC_W-1:0];
    ei[c*ACC_W +: ACC_W] = v[4][ACC_W-1:0];
    eq[c*ACC_W +: ACC_W] = v[5][ACC_W-1:0];
    ts = t;
  endtask

  function automatic logic [5:0][31:0] rnd_corr(input logic [31:0] piv);
    logic [5:0][31:0] v;
    for (int k = 0; k < 6; k++) v[k] = $urandom & AMASK;
    v[0] = piv & AMASK;
    return v;
  endfunction

  task automatic dump(input int c, input logic [31:0] piv, input logic [31:0] t);
    logic [5:0][31:0] v = rnd_corr(piv);
    set_corr(c, v, t);
    intg[c] = 1'b1;
    repeat (3) @(negedge clk);
    snap(c, v, t);
    intg[c] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [5:0][31:0] v;
    int acks;
    model_reset();
    bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0;
    bus.wb_we_i = 0; bus.wb_stb_i = 0; bus.wb_cyc_i = 0;
    intg = 0; acq = 0; ts = 0;
    pi = 0; pq = 0; li = 0; lq = 0; ei = 0; eq = 0;

    repeat (2) @(negedge clk);
    chk("rst_ack", bus.wb_ack_o, 1'b0);
    chk("rst_dat", bus.wb_dat_o, 32'h0);
    chk("rst_irq", irq, 1'b0);
    check_outs();
    rst_n = 1'b1;
    @(negedge clk);
    wb_rd("rst_ready", 10'h3C0, d);
    wb_rd("rst_ctrl", 10'h010, d);

    // byte-lane write on ch2 code_freq
    wb_wr(10'h080, 32'h2AAAAAAA, 4'hF);
    wb_wr(10'h080, 32'h00000055, 4'b0001);
    wb_rd("ch2_cf_rb", 10'h080, d);
    chk("ch2_cf_const", d, 32'h2AAAAA55);
    chk("ch2_cf_slice", code_freq[2*FREQ_W +: FREQ_W], 30'h2AAAAA55);
    check_outs();
    wb_wr(10'h050, 32'hFFFF_FFFF, 4'hF);
    wb_rd("ch1_ctrl", 10'h050, d);
    chk("ch1_ctrl_const", d, 32'h1F1);

    // ch1 snapshot
    dump(1, 32'h12345, 32'h1000);
    wb_rd("ready_ch1", 10'h3C0, d);
    chk("ready_ch1_const", d, 32'h2);
    wb_rd("ch1_pi", 10'h054, d);
    chk("ch1_pi_const", d, 32'h00012345);
    wb_rd("ch1_ts", 10'h06C, d);
    chk("ch1_ts_const", d, 32'h00001000);
    pi[ACC_W +: ACC_W] = 20'hABCDE; ts = 32'h5555;
    repeat (3) @(negedge clk);
    wb_rd("ch1_pi_hold", 10'h054, d);
    chk("ch1_pi_hold_const", d, 32'h00012345);
    wb_rd("ch1_ts_hold", 10'h06C, d);
    wb_wr(10'h3C0, 32'h2, 4'hF);

    // overrun on ch0
    dump(0, 32'h11111, 32'h2000);
    dump(0, 32'h22222, 32'h3000);
    wb_rd("ovr_ch0", 10'h3C4, d);
    chk("ovr_ch0_const", d, 32'h1);
    wb_wr(10'h3C4, 32'h1, 4'hF);
    wb_rd("ovr_clr", 10'h3C4, d);
    chk("ovr_clr_const", d, 32'h0);
    wb_rd("ch0_pi_newest", 10'h014, d);
    chk("ch0_pi_newest_const", d, 32'h22222);
    wb_wr(10'h3C0, 32'h1, 4'hF);

    // irq on ch2
    wb_wr(10'h3C8, 32'h4, 4'hF);
    v = rnd_corr($urandom);
    set_corr(2, v, 32'h4000);
    intg[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("irq_pre", irq, 1'b0);
    @(posedge clk);
    #1 chk("irq_rise", irq, 1'b1);
    snap(2, v, 32'h4000);
    @(negedge clk);
    intg[2] = 1'b0;
    repeat (3) @(negedge clk);
    bus.wb_adr_i = 10'h3C0; bus.wb_dat_i = 32'h4; bus.wb_sel_i = 4'hF;
    bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(posedge clk);
    #1 chk("irq_hold", irq, 1'b1);
    chk("ack_w1c", bus.wb_ack_o, 1'b1);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    model_write(10'h3C0, 32'h4, 4'hF);
    @(posedge clk);
    #1 chk("irq_fall", irq, 1'b0);
    @(negedge clk);
    dump(0, $urandom, $urandom);
    chk("irq_masked", irq, 1'b0);
    wb_rd("ready_ch0", 10'h3C0, d);
    wb_wr(10'h3C0, 32'h1, 4'hF);

    // simultaneous W1C and capture on ch3
    dump(3, $urandom, $urandom);
    v = rnd_corr($urandom);
    set_corr(3, v, 32'h7777);
    intg[3] = 1'b1;
    repeat (2) @(negedge clk);
    wb_wr(10'h3C0, 32'h8, 4'hF);
    snap(3, v, 32'h7777);
    intg[3] = 1'b0;
    repeat (3) @(negedge clk);
    wb_rd("simul_ready", 10'h3C0, d);
    chk("simul_ready_b3", d[3], 1'b1);
    wb_rd("simul_ovr", 10'h3C4, d);
    chk("simul_ovr_b3", d[3], 1'b0);
    wb_rd("simul_ts", 10'h0EC, d);
    wb_wr(10'h3C0, 32'h8, 4'hF);

    // unmapped and out-of-range
    wb_rd("glb_unmapped", 10'h3D0, d);
    chk("glb_unmapped_const", d, 32'h0);
    wb_rd("ch5", 10'h140, d);
    chk("ch5_const", d, 32'h0);
    wb_rd("ch1_off30", 10'h070, d);
    wb_wr(10'h140, 32'hFFFF_FFFF, 4'hF);
    wb_wr(10'h054, 32'hFFFF_FFFF, 4'hF);
    check_outs();

    // held strobe: one ack every second cycle
    bus.wb_adr_i = 10'h3C8; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.wb_ack_o) acks++;
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    chk("held_stb_acks", acks, 2);
    @(negedge clk);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      int c, o;
      case ($urandom_range(0, 4))
        0: begin
          c = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, NUM_CH - 1);
          o = 4 * $urandom_range(0, 5);
          if (o == 20) o = 44;
          wb_wr({4'(c), 6'(o)}, $urandom, 4'($urandom));
        end
        1: begin
          c = $urandom_range(0, NUM_CH);
          if (c == NUM_CH) c = 15;
          wb_rd("rnd_rd", {4'(c), 6'(4 * $urandom_range(0, 15))}, d);
        end
        2: dump($urandom_range(0, NUM_CH - 1), $urandom, $urandom);
        3: wb_wr({4'hF, 6'(4 * $urandom_range(0, 2))}, $urandom, 4'($urandom));
        default: begin
          acq = NUM_CH'($urandom);
          wb_rd("rnd_acq", 10'h3CC, d);
        end
      endcase
      chk_irq("rnd_irq");
      if (it % 16 == 15) check_outs();
    end
    wb_wr(10'h3C8, 32'hF, 4'hF);
    wb_wr(10'h0C0, 32'hFFFF_FFFF, 4'hF);
    dump(1, $urandom, $urandom);

    // reset in the middle of a write
    bus.wb_adr_i = 10'h000; bus.wb_dat_i = 32'h3FFF_FFFF; bus.wb_sel_i = 4'hF;
    bus.wb_we_i = 1'b1; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_ack", bus.wb_ack_o, 1'b0);
    model_reset();
    @(posedge clk);
    #1 chk("rst_hold_ack", bus.wb_ack_o, 1'b0);
    chk("rst_hold_irq", irq, 1'b0);
    chk("rst_hold_dat", bus.wb_dat_o, 32'h0);
    check_outs();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_rd("post_rst_cf0", 10'h000, d);
    wb_rd("post_rst_ready", 10'h3C0, d);
    wb_rd("post_rst_ien", 10'h3C8, d);
    wb_rd("post_rst_sh", 10'h054, d);
    wb_rd("post_rst_ctrl3", 10'h0D0, d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gps_wb_regbank_mc.md
Name: gps_wb_regbank_mc

Overview:
- Parametrised multi-channel Wishbone register bank for the GPS baseband engine, sitting between the Wishbone bus and NUM_CH tracking channels.
- Per channel it holds the NCO frequency and offset registers and the satellite select.
- On each integration dump it captures a coherent snapshot of the six correlator outputs and the timestamp into shadow registers.
- Adds per-channel ready/overrun flags with write-1-to-clear, a maskable interrupt, byte selects and a registered single-cycle ack.

Parameters:
- NUM_CH, 4, number of tracking channels (1..15).
- ACC_W, 20, correlator accumulator width (<=32), zero-extended on read.
- FREQ_W, 30, NCO frequency word width (<=32).

Ports:
- wb_clk_i  in  1  bus and core clock.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- wb_adr_i  in  10  byte address; [9:6] channel/global select, [5:0] register offset.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables.
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle valid.
- wb_dat_o  out  32  read data, valid while wb_ack_o=1.
- wb_ack_o  out  1  registered acknowledge.
- irq_o  out  1  registered interrupt, level.
- code_freq_o  out  NUM_CH*FREQ_W  code NCO word per channel; ch n at [n*FREQ_W +: FREQ_W].
- carr_freq_o  out  NUM_CH*FREQ_W  carrier NCO word per channel.
- code_off_o  out  NUM_CH*FREQ_W  code frequency offset per channel.
- carr_off_o  out  NUM_CH*FREQ_W  carrier frequency offset per channel.
- ch_enable_o  out  NUM_CH  channel run enable.
- sat_id_o  out  NUM_CH*5  PRN select per channel.
- pi_i, pq_i, li_i, lq_i, ei_i, eq_i  in  NUM_CH*ACC_W each  correlator dumps (prompt/late/early, I/Q).
- intg_ready_i  in  NUM_CH  dump-ready level per channel, asynchronous to wb_clk_i.
- acq_complete_i  in  NUM_CH  acquisition done, level.
- timestamp_i  in  32  free-running timestamp, shared by all channels.

Behaviour:
- Reset (wb_rst_i=0, async): every output and internal register is 0, including wb_ack_o, irq_o, wb_dat_o, flags, shadows and synchronisers.
- Handshake:
  - req = wb_cyc_i & wb_stb_i & ~wb_ack_o; wb_ack_o registers req, giving a one-cycle pulse one clock after the request.
  - A strobe held high therefore gets ack on every second cycle.
  - Every address, mapped or not, gets an ack.
  - Writes commit on the edge where req=1, byte-wise per wb_sel_i; bits beyond a field's width are ignored.
  - Reads register wb_dat_o on the same edge. Unmapped addresses and channel indices >= NUM_CH read 0; writes to them are ignored.
- Channel map (adr[9:6]=n<NUM_CH, offsets relative to base n*0x40):
  - 0x00 code_freq, RW.
  - 0x04 carr_freq, RW.
  - 0x08 code_off, RW.
  - 0x0C carr_off, RW.
  - 0x10 CTRL, RW: [0] enable, [8:4] sat_id.
  - 0x14..0x28 shadow PI, PQ, LI, LQ, EI, EQ, RO.
  - 0x2C shadow timestamp, RO.
- Global map (adr[9:6]=0xF):
  - 0x00 READY, W1C, [NUM_CH-1:0].
  - 0x04 OVERRUN, W1C.
  - 0x08 IRQ_EN, RW.
  - 0x0C ACQ, RO: acq_complete_i, sampled when the read registers.
- Dump capture per channel:
  - intg_ready_i passes through 2-FF sync s1→s2, then s3 holds the previous s2.
  - Capture event is s2 & ~s3, a rising edge.
  - On the event edge, the six correlator inputs are copied to shadows, timestamp_i to shadow ts, and READY[n] is set.
  - Input high to READY visible takes 3 clock edges.
  - Shadows hold until the next event.
- Overrun: an event while READY[n]=1 and READY[n] is not cleared in that same cycle sets OVERRUN[n]. The snapshot is still overwritten (newest wins).
- Simultaneous W1C clear and capture event on the same bit: the set wins, READY stays 1, and OVERRUN is not set.
- irq_o is the registered |(READY & IRQ_EN), so it follows the flag or enable change by one cycle.
- A falling edge on intg_ready_i causes no action. A pulse shorter than 2 clocks may be missed; this is permitted.
- Reset mid-transaction: ack is dropped immediately and the pending write is lost.

Test Plan:
- Write ch2 0x80 = 0x2AAAAAAA with sel=4'hF, then sel=4'b0001 with data 0x55 → ack exactly 1 cycle after stb; readback 0x2AAAAA55; code_freq_o ch2 slice = 0x2AAAAA55; other channels stay 0.
- ch1 pi_i=0x12345, ts=0x1000; raise intg_ready_i[1] → READY=0x2 after 3 edges; read 0x54 → 0x00012345; read 0x6C → 0x00001000; inputs changed afterwards leave the reads unchanged.
- Two dumps on ch0 without clearing → OVERRUN=0x1; W1C 0x1 to 0x3C4 clears it; the second dump's data is in the shadows.
- IRQ_EN=0x4 and ch2 dump → irq_o rises 1 cycle after READY[2]; W1C 0x4 to 0x3C0 → irq_o falls 1 cycle later; a ch0 dump alone never raises irq_o.
- W1C of READY[3] in the same cycle as a ch3 capture event → READY[3]=1, OVERRUN[3]=0.
- Read 0x3C0 region offset 0x10 and channel 5 with NUM_CH=4 → ack, data 0; assert reset during a write → ack=0 and all registers 0.
